// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the program counter, addresses the combinational
// instruction memory and fills the IF/ID pipeline register (bubbles on redirect).
module instruction_fetch #(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32,
    parameter int RESET_PC    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [INS_ADDRESS-1:0] redirect_pc,
    output logic [INS_ADDRESS-1:0] imem_ra,
    input  logic [INS_W-1:0]       imem_rd,
    output logic [INS_ADDRESS-1:0] if_id_pc,
    output logic [INS_W-1:0]       if_id_instr,
    output logic                   if_id_valid,
    output logic [31:0]            fetch_count
);

    localparam logic [INS_W-1:0]       NOP_INSTR = INS_W'(32'h0000_0013);
    localparam logic [INS_ADDRESS-1:0] PC_START  = INS_ADDRESS'(RESET_PC) & ~INS_ADDRESS'(3);
    localparam logic [INS_ADDRESS-1:0] PC_STEP   = INS_ADDRESS'(4);

    logic [INS_ADDRESS-1:0] pc;
    logic [INS_ADDRESS-1:0] redirect_target;
    logic                   unused_redirect_low_bits;

    // Targets are word aligned; the byte-offset bits from execute are dropped.
    assign redirect_target          = {redirect_pc[INS_ADDRESS-1:2], 2'b00};
    assign unused_redirect_low_bits = ^redirect_pc[1:0];

    assign imem_ra = pc;

    // Priority: reset, then redirect (even while stalled), then stall, then run.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= PC_START;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else if (redirect) begin
            pc          <= redirect_target;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            pc          <= pc + PC_STEP;
            if_id_pc    <= pc;
            if_id_instr <= imem_rd;
            if_id_valid <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a small combinational
// instruction memory model (128 words, 9-bit byte address).
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [8:0]  redirect_pc;
    logic [8:0]  imem_ra;
    logic [31:0] imem_rd;
    logic [8:0]  if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    logic [31:0] imem [0:127];

    int tests_run    = 0;
    int tests_failed = 0;

    instruction_fetch #(
        .INS_ADDRESS(9),
        .INS_W(32),
        .RESET_PC(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_ra(imem_ra),
        .imem_rd(imem_rd),
        .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rd = imem[imem_ra[8:2]];

    // Drive one cycle of inputs, take the edge, and settle before sampling.
    task automatic applyStimulus(input logic rst, input logic stl, input logic redir,
                                 input logic [8:0] target);
        reset       = rst;
        stall       = stl;
        redirect    = redir;
        redirect_pc = target;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic [8:0] exp_pc,
                              input logic [8:0] exp_if_pc, input logic [31:0] exp_instr,
                              input logic exp_valid, input logic [31:0] exp_count);
        checkOutput({tag, " pc"},       32'(imem_ra),     32'(exp_pc));
        checkOutput({tag, " if_id_pc"}, 32'(if_id_pc),    32'(exp_if_pc));
        checkOutput({tag, " instr"},    if_id_instr,      exp_instr);
        checkOutput({tag, " valid"},    32'(if_id_valid), 32'(exp_valid));
        checkOutput({tag, " count"},    fetch_count,      exp_count);
    endtask

    function automatic logic [31:0] fillWord(input int idx);
        return 32'hA500_0000 | 32'(idx);
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 128; i++) imem[i] = fillWord(i);
        imem[0]  = 32'h0000_7033;
        imem[1]  = 32'h0010_0093;
        imem[2]  = 32'h0020_0113;
        imem[3]  = 32'h0030_8193;
        imem[21] = 32'h0000_8413;

        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
        checkState("reset", 9'h000, 9'h000, 32'h0000_0013, 1'b0, 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        checkState("run0", 9'h004, 9'h000, 32'h0000_7033, 1'b1, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        checkState("run1", 9'h008, 9'h004, 32'h0010_0093, 1'b1, 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        checkState("run2", 9'h00C, 9'h008, 32'h0020_0113, 1'b1, 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        checkState("run3", 9'h010, 9'h00C, 32'h0030_8193, 1'b1, 32'd4);

        // Advance from 0x10 to 0x34 (9 more fetches).
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        checkState("pre_redir", 9'h034, 9'h030, fillWord(12), 1'b1, 32'd13);

        applyStimulus(1'b0, 1'b0, 1'b1, 9'h054);
        checkState("redir_bubble", 9'h054, 9'h000, 32'h0000_0013, 1'b0, 32'd13);
        applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        checkState("redir_target", 9'h058, 9'h054, 32'h0000_8413, 1'b1, 32'd14);

        applyStimulus(1'b0, 1'b0, 1'b1, 9'h01C);
        applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        checkState("pre_stall", 9'h020, 9'h01C, fillWord(7), 1'b1, 32'd15);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
            checkState($sformatf("stall%0d", i), 9'h020, 9'h01C, fillWord(7), 1'b1, 32'd15);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        checkState("stall_release", 9'h024, 9'h020, fillWord(8), 1'b1, 32'd16);

        applyStimulus(1'b0, 1'b1, 1'b1, 9'h03E);
        checkState("stall_redir", 9'h03C, 9'h000, 32'h0000_0013, 1'b0, 32'd16);

        applyStimulus(1'b0, 1'b0, 1'b1, 9'h1FC);
        checkState("pre_wrap", 9'h1FC, 9'h000, 32'h0000_0013, 1'b0, 32'd16);
        applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        checkState("wrap", 9'h000, 9'h1FC, fillWord(127), 1'b1, 32'd17);

        applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        applyStimulus(1'b1, 1'b0, 1'b1, 9'h080);
        checkState("reset_redir", 9'h000, 9'h000, 32'h0000_0013, 1'b0, 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        checkState("post_reset", 9'h004, 9'h000, 32'h0000_7033, 1'b1, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 9'h004);
        checkState("redir_same_pc", 9'h004, 9'h000, 32'h0000_0013, 1'b0, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        checkState("after_same_pc", 9'h008, 9'h004, 32'h0010_0093, 1'b1, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch (IF) stage of the five-stage RISC-V pipeline. It holds the program counter and drives the byte address into the combinational instruction memory. It captures the returned instruction word into the IF/ID pipeline register consumed by decode. It honours hazard-unit stalls and branch/jump redirects from execute, inserting NOP bubbles on redirect.

## Interface
Parameters:
- `INS_ADDRESS`, 9: PC / instruction-memory byte-address width.
- `INS_W`, 32: instruction width.
- `RESET_PC`, 0: PC value loaded on reset; must be a multiple of 4.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hazard unit; hold PC and IF/ID contents.
- `redirect` in 1: execute stage; branch taken, `jal` or `jalr`.
- `redirect_pc` in INS_ADDRESS: redirect target byte address.
- `imem_ra` out INS_ADDRESS: read address to instruction memory `ra`; equals the current PC.
- `imem_rd` in INS_W: instruction word from instruction memory `rd`, combinational.
- `if_id_pc` out INS_ADDRESS: PC of the latched instruction.
- `if_id_instr` out INS_W: latched instruction.
- `if_id_valid` out 1: latched instruction is real (0 = bubble).
- `fetch_count` out 32: count of instructions latched with valid=1.

## Operation
- State: `pc`, IF/ID register {pc, instr, valid}, `fetch_count`.
- `imem_ra = pc`, driven combinationally. Instruction memory is read combinationally; `imem_rd` is sampled at the same edge.
- Per-edge priority:
  - `reset`:
    - pc ← RESET_PC.
    - if_id_instr ← 32'h00000013 (NOP).
    - if_id_pc ← 0; if_id_valid ← 0; fetch_count ← 0.
  - `redirect` (wins over stall):
    - pc ← {redirect_pc[INS_ADDRESS-1:2], 2'b00}; low two bits are ignored.
    - IF/ID ← bubble: NOP, valid 0, if_id_pc ← 0.
    - fetch_count unchanged.
  - `stall`: pc, IF/ID and fetch_count all hold.
  - Normal:
    - pc ← pc + 4, modulo 2^INS_ADDRESS.
    - if_id_instr ← imem_rd; if_id_pc ← pc; if_id_valid ← 1.
    - fetch_count ← fetch_count + 1, wrapping at 2^32.
- Arithmetic: PC increment uses INS_ADDRESS bits; the carry out is discarded. When INS_ADDRESS=9, 0x1FC wraps to 0x000.
- The pc register bits [1:0] are always 0.
- No internal FSM beyond the reset / redirect / stall / run decision above.
- All outputs are registered except `imem_ra`, which is pc itself and therefore also comes from a register.

## Timing
- Fetch latency: instruction at address A appears on `if_id_instr` 1 cycle after the cycle in which pc==A.
- First valid instruction after reset deassert: at edge 1, if_id gets word at RESET_PC and pc becomes RESET_PC+4.
- Redirect penalty: a redirect asserted in cycle n gives pc=target and a bubble in IF/ID in cycle n+1. The target instruction is in IF/ID in cycle n+2.
- Stall with no redirect: outputs are bit-identical for every stalled cycle. Fetching resumes from the held pc on the first non-stalled edge; no instruction is lost or duplicated.
- Simultaneous stall+redirect: redirect behaviour applies (target loaded, bubble inserted).
- Reset mid-run, including during stall or redirect: reset values apply at that edge, and the pending redirect is discarded.
- Redirect to the current pc is legal: pc reloads and a bubble is still inserted.

## Test plan
- Reset, then 4 run cycles with memory loaded 00007033, 00100093, 00200113, 00308193:
  - if_id_instr sequence: 00000013 (reset), 00007033, 00100093, 00200113, 00308193.
  - if_id_pc: 0, 0, 4, 8, 0xC.
  - fetch_count ends at 4.
- Redirect while pc=0x34 with redirect_pc=0x54:
  - Next cycle: pc=0x54, if_id_valid=0, if_id_instr=00000013.
  - Following cycle: if_id_pc=0x54, instr=00008413, valid=1.
- Stall held 3 cycles at pc=0x20:
  - pc, if_id_* and fetch_count stay constant.
  - Release: if_id_pc=0x20, pc=0x24.
- Stall and redirect together with redirect_pc=0x3E:
  - pc=0x3C (low bits cleared), bubble in IF/ID.
  - fetch_count unchanged.
- Wrap: pc=0x1FC, run 1 cycle:
  - pc=0x000, if_id_pc=0x1FC.
- Reset asserted in the same cycle as redirect to 0x80:
  - pc=RESET_PC, if_id_valid=0, fetch_count=0.
